// File: rtl/jump_ctrl.sv
// ============================================================================
// Module   : jump_ctrl
// Function : Button synchronizer, step-rate debouncer, edge detector and a
//            bounded-duration jump FSM with cooldown and a saturating jump count.
//            Optional macro JUMP_RETRIGGER_EN lets a press restart a jump.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jump_ctrl #(
    parameter int DEBOUNCE_CYC   = 4,
    parameter int JUMP_TICKS     = 40,
    parameter int COOLDOWN_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    input  logic       game_en,
    input  logic       btn,
    output logic       jump,
    output logic [1:0] state,
    output logic [7:0] jump_count
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_ascend   = 2'd1;
    localparam logic [1:0] c_cooldown = 2'd2;

    localparam logic [9:0] c_db_last  = 10'(DEBOUNCE_CYC - 1);
    localparam logic [9:0] c_jump     = 10'(JUMP_TICKS);
    localparam logic [9:0] c_cool     = 10'(COOLDOWN_TICKS);

    logic       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [9:0] db_cnt_q, db_cnt_d;
    logic       btn_db_q, btn_db_d, btn_db_dly_q, btn_db_dly_d;
    logic       press_q, press_d;
    logic [1:0] state_q, state_d;
    logic [9:0] tcnt_q, tcnt_d;
    logic       jump_q, jump_d;
    logic [7:0] jump_count_q, jump_count_d;
    logic       press_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            btn_db_q     <= 1'b0;
            btn_db_dly_q <= 1'b0;
            press_q      <= 1'b0;
            state_q      <= c_idle;
            tcnt_q       <= '0;
            jump_q       <= 1'b0;
            jump_count_q <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_dly_d;
            press_q      <= press_d;
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            jump_q       <= jump_d;
            jump_count_q <= jump_count_d;
        end
    end

    // Front end: synchronizer, debouncer (counts disagreeing strobes), edge detect
    always_comb begin
        sync1_d      = btn;
        sync2_d      = sync1_q;
        db_cnt_d     = db_cnt_q;
        btn_db_d     = btn_db_q;
        if (sync2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (step_en) begin
            if (db_cnt_q == c_db_last) begin
                btn_db_d = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 10'd1;
            end
        end
        btn_db_dly_d = btn_db_q;
        press_d      = btn_db_q & ~btn_db_dly_q;
    end

`ifdef JUMP_RETRIGGER_EN
    assign press_go = press_q;
`else
    assign press_go = press_q & (state_q == c_idle);
`endif

    // Next-state: a loaded press wins over the step on the same cycle
    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        jump_count_d = jump_count_q;
        if (!game_en) begin
            state_d      = c_idle;
            tcnt_d       = '0;
            jump_count_d = '0;
        end else if (press_go) begin
            state_d = c_ascend;
            tcnt_d  = c_jump;
            if (jump_count_q != 8'hFF) begin
                jump_count_d = jump_count_q + 8'd1;
            end
        end else begin
            case (state_q)
                c_idle: ;
                c_ascend: begin
                    if (step_en) begin
                        tcnt_d = tcnt_q - 10'd1;
                        if (tcnt_q == 10'd1) begin
                            if (c_cool != 10'd0) begin
                                state_d = c_cooldown;
                                tcnt_d  = c_cool;
                            end else begin
                                state_d = c_idle;
                            end
                        end
                    end
                end
                c_cooldown: begin
                    if (step_en) begin
                        tcnt_d = tcnt_q - 10'd1;
                        if (tcnt_q == 10'd1) begin
                            state_d = c_idle;
                        end
                    end
                end
                default: begin
                    state_d = c_idle;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        jump_d = (state_d == c_ascend);
    end

    assign jump       = jump_q;
    assign state      = state_q;
    assign jump_count = jump_count_q;

endmodule

`default_nettype wire

// File: doc/jump_ctrl.md
# jump_ctrl

- Converts the raw player jump button into the clean, time-limited `jump` level that the sprite position stage consumes.
- The position stage climbs one pixel per step while `jump` is high and falls otherwise.
- Pipeline: 2-flop synchronizer, step-rate debouncer, rising-edge detector, then a three-state jump FSM that bounds jump duration and enforces a cooldown.
- Also keeps a saturating count of jumps taken, for the score/HUD logic.

## Interface
Parameters:
- `DEBOUNCE_CYC`, 4: consecutive `step_en` samples needed to accept a button level change; legal range 1–15.
- `JUMP_TICKS`, 40: `step_en` strobes per jump (0.4 s at the 100 Hz step rate); legal range 1–1023.
- `COOLDOWN_TICKS`, 10: `step_en` strobes with `jump` forced low after each jump; legal range 0–1023.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `step_en`  in  1  one-cycle game step strobe; all timing is counted in these strobes.
- `game_en`  in  1  high while a game is running.
- `btn`  in  1  raw, asynchronous, bouncing button; active-high.
- `jump`  out  1  registered jump request to the position stage.
- `state`  out  2  FSM state: 0 IDLE, 1 ASCEND, 2 COOLDOWN.
- `jump_count`  out  8  jumps started; saturates at 255.

## Operation
Synchronizer:
- `btn` passes through two flops, giving `btn_s`.

Debouncer (10-bit counter `db_cnt`, registered level `btn_db`):
- When `btn_s == btn_db`, `db_cnt` is cleared to 0.
- Otherwise, on a `step_en` cycle, `db_cnt` increments.
- When `step_en` arrives with `db_cnt == DEBOUNCE_CYC-1`: `btn_db <= btn_s` and `db_cnt <= 0`.

Edge detector:
- `press` is registered and equals `btn_db & ~btn_db_q`.
- It is high for exactly one cycle per accepted rising edge.

FSM (10-bit down-counter `tcnt`):
- IDLE: `jump`=0. On `press` with `game_en`=1, go to ASCEND, load `tcnt=JUMP_TICKS`, increment `jump_count` (saturating).
- ASCEND: `jump`=1. On each `step_en`, decrement `tcnt`. When `step_en` arrives with `tcnt==1`:
  - if `COOLDOWN_TICKS>0`, go to COOLDOWN and load `tcnt=COOLDOWN_TICKS`;
  - otherwise go straight to IDLE.
- COOLDOWN: `jump`=0. On each `step_en`, decrement `tcnt`. When `step_en` arrives with `tcnt==1`, go to IDLE.
- Presses outside IDLE are discarded, unless the configuration macro below is defined.
- Encoding 3 is illegal and recovers to IDLE on the next edge.

`game_en` and boundary cases:
- `game_en`=0 has priority over everything. On the next edge: state to IDLE, `tcnt`=0, `jump`=0, `jump_count`=0. The debouncer keeps running.
- A `press` coinciding with `step_en` in IDLE: the step is not counted; the full `JUMP_TICKS` still applies.
- A button held down produces exactly one jump; a new jump needs a debounced release and a new press.

Reset (`rst_n` low, any time, including mid-jump): all outputs and internal state clear immediately:
- `jump`=0, `state`=0, `jump_count`=0, `btn_db`=0, `db_cnt`=0, `tcnt`=0, synchronizer flops 0.

## Timing
- `jump`, `state` and `jump_count` are registered and glitch-free.
- Latency from the `step_en` edge that updates `btn_db` high:
  - `press` high 1 cycle later;
  - `jump` high 2 cycles later.
- Minimum latency from a clean `btn` rise to `jump`: 2 synchronizer cycles, plus `DEBOUNCE_CYC` strobes, plus 2 cycles.
- `jump` stays high across exactly `JUMP_TICKS` `step_en` strobes. It falls on the edge of the `JUMP_TICKS`-th strobe.
- The earliest re-jump is `COOLDOWN_TICKS` strobes after `jump` falls, plus 2 cycles of FSM latency.

## Configuration
- `JUMP_RETRIGGER_EN` defined: a `press` in ASCEND reloads `tcnt=JUMP_TICKS` and stays in ASCEND. A `press` in COOLDOWN goes to ASCEND with `tcnt=JUMP_TICKS`. Each such press increments `jump_count`.
- `JUMP_RETRIGGER_EN` undefined: presses in ASCEND or COOLDOWN are ignored and `jump_count` does not change.

## Test plan
- Reset: `rst_n` low mid-ASCEND -> same cycle `jump`=0, `state`=0, `jump_count`=0; release `rst_n` with `btn` low -> stays IDLE.
- Bounce rejection (DEBOUNCE_CYC=4, `step_en` every cycle): `btn` toggles high/low every 2 cycles for 20 cycles, then stays low -> `jump` never rises, `jump_count`=0.
- Clean jump (defaults, `step_en` every 10 cycles): `btn` held high -> `jump` high for exactly 40 strobes, then `state`=2 for 10 strobes, then 0; `jump_count`=1; held button gives no second jump.
- Cooldown lockout (retrigger undefined): press released and re-pressed during COOLDOWN -> ignored, `jump_count` stays 1. Same stimulus with `JUMP_RETRIGGER_EN` -> ASCEND re-entered, `jump_count`=2, `jump` high 40 strobes from that press.
- Game disable: `game_en` dropped at ASCEND strobe 15 -> next edge `jump`=0, `state`=0, `jump_count`=0; a press while `game_en`=0 -> no jump.
- Saturation and edge parameters: 260 jumps with COOLDOWN_TICKS=0 and JUMP_TICKS=1 -> `jump_count`=255, `jump` high for exactly 1 strobe, ASCEND goes directly to IDLE.
